seg7_bcd_display: RTL and testbench
===================================

// Module: seg7_bcd_display
// PURPOSE
//   Registered, parametrised signed-binary to multi-digit 7-segment display driver.
//   Accepts one sample per valid/ready handshake and converts it with a sequential
//   shift-add-3 (double-dabble) BCD converter.
//   Holds the rendered digits until the next accepted sample.
//   Sits between the CORDIC angle outputs / accelerometer data registers and HEX0..HEXn.
// PARAMETERS
//   DATA_W  9  input width in bits; two's complement when SIGNED=1
//   DIGITS  3  number of decimal magnitude digits (1..6); one extra sign digit on top
//   SIGNED  1  1: i_data is two's complement; 0: i_data is unsigned, sign digit always blank
// PORTS
//   i_clk     in   1              system clock; the only clock
//   i_rst_n   in   1              reset, asynchronous, active-low
//   i_data    in   DATA_W         sample to display
//   i_valid   in   1              sample present
//   o_ready   out  1              converter idle; sample accepted when i_valid && o_ready
//   o_seg     out  (DIGITS+1)*8   segment bytes, active-low {DP,g..a}
//                                 [7:0] = ones digit ... [DIGITS*8+:8] = sign digit
//   o_done    out  1              1-cycle pulse in the cycle o_seg takes the new value
//   o_ovf     out  1              last displayed sample exceeded 10^DIGITS-1; sticky until next done
// BEHAVIOUR
//   Reset (async assert, sync release)
//     o_ready=1, o_done=0, o_ovf=0; sign byte 8'hFF.
//     Magnitude bytes 8'hC0 (displays "0").
//     In-flight conversion abandoned; no o_done follows.
//   States and transitions: IDLE -> LOAD -> SHIFT -> OUT -> IDLE.
//   IDLE: o_ready=1. On accept, latch:
//     neg = SIGNED & i_data[DATA_W-1]
//     mag = neg ? -i_data : i_data   (DATA_W bits, so -2^(DATA_W-1) is exact)
//     ovf = mag > 10^DIGITS-1
//   LOAD: clear the BCD register (4*DIGITS bits) and the shift counter.
//   SHIFT: runs exactly DATA_W cycles. Each cycle:
//     every BCD nibble >= 5 gets +3;
//     then {bcd,mag} shifts left by 1.
//     Counter wraps to 0 and the FSM leaves SHIFT after count DATA_W-1.
//   OUT: update o_seg, o_ovf; o_done=1 for this single cycle. Next state IDLE.
//   o_ready is 0 in LOAD, SHIFT and OUT.
//   Latency: accept in cycle N gives o_done/new o_seg in cycle N+DATA_W+2.
//   Throughput: one sample per DATA_W+3 cycles.
//   i_valid while busy: ignored and not queued; upstream holds or drops it.
//   Digit encoding (team table)
//     0..9 = C0 F9 A4 B0 99 92 82 F8 80 98
//     minus = BF, blank = FF
//   Sign digit: BF when neg, else FF.
//   ovf=1: all magnitude digits show 9 (saturate); sign is still shown.
//   o_seg changes only in OUT; it is glitch-free between updates.
// CONFIGURATION
//   SEG7_LZB_EN defined
//     Leading-zero blanking: zero digits above the most significant nonzero digit show FF.
//     The ones digit is never blanked. The sign stays in the dedicated top digit.
//     The reset display is: ones digit C0, all others FF.
//   SEG7_LZB_EN undefined
//     All magnitude digits are always shown, including leading zeros.
// STRUCTURE
//   seg7_pkg holds:
//     segment constants SEG_BLANK, SEG_MINUS, SEG_DIGIT[0:9];
//     the state enum typedef;
//     function bcd_to_seg(logic [3:0]) -> logic [7:0].
//   Sub-module bin2bcd_seq #(IN_W, DIGITS) contains the LOAD/SHIFT datapath and counter.
//     Ports: start, busy, done, bcd.
//   The top level holds the handshake, sign/magnitude, overflow compare and output registers.
// TESTING
//   DATA_W=9 DIGITS=3, i_data=+45 -> after 11 cycles o_done=1, o_seg={FF,C0,99,92}, o_ovf=0
//   i_data=-180 (9'h14C) -> o_seg={BF,F9,80,C0}
//   i_data=-256 (9'h100) -> o_seg={BF,A4,92,82}; confirms most-negative handling
//   DATA_W=12, i_data=1500 -> o_seg={FF,98,98,98}, o_ovf=1
//     then i_data=12 -> o_ovf=0
//   Pulse i_valid=+7 in the 3rd SHIFT cycle of a conversion -> ignored;
//     exactly one o_done, for the first sample
//   Assert i_rst_n=0 mid-SHIFT -> o_seg={FF,C0,C0,C0}, o_ready=1, no o_done
//     With SEG7_LZB_EN: reset gives {FF,FF,FF,C0}; +7 gives {FF,FF,FF,F8}

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment BCD display driver.
//   SEG_BLANK / SEG_MINUS / SEG_DIGIT[0:9] : active-low {DP,g..a} segment bytes
//   state_e                                : display controller FSM states
//   bcd_to_seg()                           : one BCD nibble -> segment byte
//   pow10()                                : 10^n, for the overflow threshold
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h98
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_OUT
    } state_e;

    // Non-decimal nibbles can only appear when the value overflowed the
    // available digits; those are saturated upstream, so blank is a safe pick.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_DIGIT[0];
            4'd1:    return SEG_DIGIT[1];
            4'd2:    return SEG_DIGIT[2];
            4'd3:    return SEG_DIGIT[3];
            4'd4:    return SEG_DIGIT[4];
            4'd5:    return SEG_DIGIT[5];
            4'd6:    return SEG_DIGIT[6];
            4'd7:    return SEG_DIGIT[7];
            4'd8:    return SEG_DIGIT[8];
            4'd9:    return SEG_DIGIT[9];
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to BCD converter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load bin_i, clear BCD register and counter (one cycle)
//   bin_i         : unsigned value to convert (IN_W bits)
//   busy_o        : shifting in progress (IN_W cycles after start)
//   done_o        : high during the last shift cycle
//   bcd_o         : BCD value the register takes at the end of this cycle;
//                   holds the final result whenever done_o is high
module bin2bcd_seq #(
    parameter int IN_W   = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [IN_W-1:0]       bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    logic [IN_W-1:0]          bin_q, bin_d;
    logic [4*DIGITS-1:0]      bcd_q, bcd_d, adj;
    logic [4*DIGITS+IN_W-1:0] sr;
    logic [CNT_W-1:0]         cnt_q;
    logic                     busy_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        sr    = {adj, bin_q} << 1;
        bcd_d = sr[IN_W +: 4*DIGITS];
        bin_d = sr[IN_W-1:0];
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_LAST);
    // Exposing the next value lets the caller register the result on the
    // same edge as the final shift, saving a cycle of latency.
    assign bcd_o  = bcd_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display: registered signed-binary to multi-digit 7-segment driver.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_data/i_valid : sample, accepted when i_valid && o_ready
//   o_ready        : idle, able to accept a sample
//   o_seg          : active-low segment bytes, [7:0] ones ... top byte = sign
//   o_done         : one-cycle pulse when o_seg takes a new value
//   o_ovf          : last displayed magnitude exceeded 10^DIGITS-1 (shows 9s)
// Build option: define SEG7_LZB_EN for leading-zero blanking.
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [(DIGITS+1)*8-1:0] o_seg,
    output logic                    o_done,
    output logic                    o_ovf
);
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [63:0] MAX_MAG = 64'(pow10(DIGITS) - 1);

    state_e                  state_q, state_d;
    logic                    neg_q, neg_d, ovf_q, ovf_d;
    logic [DATA_W-1:0]       mag_q, mag_d;
    logic [(DIGITS+1)*8-1:0] seg_q, seg_d;
    logic                    done_q, ovf_out_q;
    logic                    accept, conv_busy, conv_done, load_out, lead;
    logic [4*DIGITS-1:0]     conv_bcd;

    assign o_ready  = (state_q == ST_IDLE) && !conv_busy;
    assign accept   = i_valid && o_ready;
    assign load_out = (state_q == ST_SHIFT) && conv_done;
    assign o_seg    = seg_q;
    assign o_done   = done_q;
    assign o_ovf    = ovf_out_q;

    // Negating in DATA_W bits maps -2^(DATA_W-1) onto its exact unsigned magnitude.
    assign neg_d = (SIGNED != 0) && i_data[DATA_W-1];
    assign mag_d = neg_d ? -i_data : i_data;
    assign ovf_d = 64'(mag_d) > MAX_MAG;

    bin2bcd_seq #(.IN_W(DATA_W), .DIGITS(DIGITS)) u_conv (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .start_i (state_q == ST_LOAD),
        .bin_i   (mag_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (conv_done) state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Walk from the top digit down; 'lead' stays set while only zeros seen.
    always_comb begin
        seg_d = '0;
        lead  = LZB;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (conv_bcd[4*i +: 4] != 4'd0) lead = 1'b0;
            if (ovf_q)
                seg_d[8*i +: 8] = SEG_DIGIT[9];
            else if (lead && (i != 0))
                seg_d[8*i +: 8] = SEG_BLANK;
            else
                seg_d[8*i +: 8] = bcd_to_seg(conv_bcd[4*i +: 4]);
        end
        seg_d[8*DIGITS +: 8] = neg_q ? SEG_MINUS : SEG_BLANK;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
            seg_q[8*DIGITS +: 8] <= SEG_BLANK;
            for (int i = 0; i < DIGITS; i++)
                seg_q[8*i +: 8] <= (LZB && (i != 0)) ? SEG_BLANK : SEG_DIGIT[0];
        end else begin
            state_q <= state_d;
            done_q  <= load_out;
            if (accept) begin
                neg_q <= neg_d;
                mag_q <= mag_d;
                ovf_q <= ovf_d;
            end
            if (load_out) begin
                seg_q     <= seg_d;
                ovf_out_q <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb_seg7_bcd_display: scoreboard bench for seg7_bcd_display.
// Two instances: DATA_W=9 (a) and DATA_W=12 (b, reaches overflow), DIGITS=3.
// Honours SEG7_LZB_EN the same way as the design.
module tb_seg7_bcd_display;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [31:0] seg;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  dat_a = '0;
    logic [11:0] dat_b = '0;
    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic        rdy_a, rdy_b, done_a, done_b, ovf_a, ovf_b;
    logic [31:0] seg_a, seg_b;
    logic [7:0]  tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};
    exp_t        qa[$], qb[$];
    int          cyc = 0;
    int          ncmp = 0, nmis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_bcd_display #(.DATA_W(9), .DIGITS(3), .SIGNED(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(dat_a), .i_valid(vld_a),
        .o_ready(rdy_a), .o_seg(seg_a), .o_done(done_a), .o_ovf(ovf_a)
    );
    seg7_bcd_display #(.DATA_W(12), .DIGITS(3), .SIGNED(1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(dat_b), .i_valid(vld_b),
        .o_ready(rdy_b), .o_seg(seg_b), .o_done(done_b), .o_ovf(ovf_b)
    );

    // Display as a person would read it: signed value, abs, decimal digits.
    function automatic exp_t model(input int w, input logic [11:0] raw);
        exp_t e;
        int v, mag, p, d;
        bit neg;
        v   = int'(raw) & ((1 << w) - 1);
        neg = v >= (1 << (w - 1));
        mag = neg ? (1 << w) - v : v;
        e.ovf = mag > 999;
        e.seg = '0;
        p = 1;
        for (int k = 0; k < 3; k++) begin
            d = e.ovf ? 9 : (mag / p) % 10;
            if (LZB && !e.ovf && k > 0 && mag < p) e.seg[8*k +: 8] = 8'hFF;
            else                                    e.seg[8*k +: 8] = tbl[d];
            p = p * 10;
        end
        e.seg[31:24] = neg ? 8'hBF : 8'hFF;
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_done(input int which, input logic [31:0] s, input logic o);
        exp_t e;
        ncmp++;
        if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
            nmis++;
            $display("FAIL unexpected_done dut%0d: seg %h at cycle %0d, none expected", which, s, cyc);
        end else begin
            e = (which == 0) ? qa.pop_front() : qb.pop_front();
            if (s !== e.seg || o !== e.ovf || cyc != e.cyc) begin
                nmis++;
                $display("FAIL result dut%0d: seg %h ovf %b cycle %0d, expected seg %h ovf %b cycle %0d",
                         which, s, o, cyc, e.seg, e.ovf, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done_a) check_done(0, seg_a, ovf_a);
        if (done_b) check_done(1, seg_b, ovf_b);
    end

    // Present a sample, wait for acceptance, queue its expected display.
    task automatic send(input int which, input logic [11:0] v, input bit track);
        int n;
        exp_t e;
        @(negedge clk);
        if (which == 0) begin dat_a = v[8:0]; vld_a = 1'b1; end
        else            begin dat_b = v;      vld_b = 1'b1; end
        n = 0;
        while (((which == 0) ? rdy_a : rdy_b) == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            ncmp++; nmis++;
            $display("FAIL ready_timeout dut%0d: o_ready stayed 0, expected 1", which);
        end else if (track) begin
            e = model((which == 0) ? 9 : 12, v);
            e.cyc = cyc + ((which == 0) ? 11 : 14);
            if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            ncmp++; nmis++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", qa.size(), qb.size());
        end
    endtask

    logic [31:0] rst_seg;
    logic [11:0] dir_a [6] = '{12'd45, 12'h14C, 12'h100, 12'd0, 12'd7, 12'd255};
    logic [11:0] dir_b [6] = '{12'd1500, 12'd12, 12'h800, 12'd999, 12'd1000, 12'hC19};

    initial begin
        rst_seg = LZB ? 32'hFFFF_FFC0 : 32'hFFC0_C0C0;
        repeat (3) @(negedge clk);
        chk("reset_seg_a", seg_a, rst_seg);
        chk("reset_seg_b", seg_b, rst_seg);
        chk("reset_flags_a", {29'd0, rdy_a, done_a, ovf_a}, 32'd4);
        chk("reset_flags_b", {29'd0, rdy_b, done_b, ovf_b}, 32'd4);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready_a", {31'd0, rdy_a}, 32'd1);

        for (int i = 0; i < 6; i++) send(0, dir_a[i], 1'b1);
        for (int i = 0; i < 6; i++) send(1, dir_b[i], 1'b1);
        drain();
        for (int i = 0; i < 15; i++) send(0, 12'($urandom_range(0, 511)), 1'b1);
        for (int i = 0; i < 15; i++) send(1, 12'($urandom_range(0, 4095)), 1'b1);
        drain();

        // A second sample offered in the 3rd SHIFT cycle must be dropped.
        send(0, 12'd123, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_ready_a", {31'd0, rdy_a}, 32'd0);
        dat_a = 9'd7;
        vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Reset mid-SHIFT: default display, ready, and no done afterwards.
        send(0, 12'h0AA, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg_a", seg_a, rst_seg);
        chk("midrst_flags_a", {29'd0, rdy_a, done_a, ovf_a}, 32'd4);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(0, 12'd7, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
